hc165_scan_ctrl: RTL and testbench
==================================

# hc165_scan_ctrl

Sequencing controller for a daisy-chain of N_CHIPS 74HC165 parallel-in/serial-out shift registers. It drives the chain's SH/LD and clock-inhibit lines, pulses the shift enable at a programmable rate, and deserialises QH into a parallel word. It publishes each completed scan with a one-cycle valid strobe and a change flag. It sits between the input-expander chain and the register/host logic that consumes switch or sensor snapshots.

## Interface
- N_CHIPS, 2: number of cascaded 8-bit registers; word width W = 8*N_CHIPS.
- DIV, 4: system-clock cycles per bit period (one shift-enable cycle plus DIV-1 inhibited cycles); legal DIV >= 2.
- QH_LAT, 1: enabled clock edges between the load edge and the first bit appearing on QH. Use 1 for the registered-QH chip model and 0 for a combinational-QH part.
- clk  in  1  system clock; the chain is clocked by the same clk.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a single scan; sampled only in IDLE.
- auto_scan  in  1  when high, re-scan back-to-back without start.
- sr_qh  in  1  QH of the last chip in the chain.
- sr_shift_load  out  1  to every chip's shift_load: 0 = load, 1 = shift.
- sr_clk_inh  out  1  to every chip's clock_in_hibit: 1 = hold, 0 = clock enabled.
- data  out  W  last completed scan; the first bit received is at data[W-1].
- valid  out  1  one-cycle strobe when data updates.
- changed  out  1  one-cycle strobe with valid when the new data differs from the previous data.
- busy  out  1  high from LOAD through DONE inclusive.

## Operation
- States: IDLE, LOAD, WAIT, PULSE, DONE.
- IDLE: sr_clk_inh=1, sr_shift_load=1. Go to LOAD when start or auto_scan is high.
- LOAD: one cycle with sr_shift_load=0 and sr_clk_inh=0; the chain captures its parallel inputs on this edge, which is edge count e=0. Clear bit counter and shadow register. Go to WAIT.
- WAIT: DIV-1 cycles with sr_clk_inh=1 and sr_shift_load=1. On the last WAIT cycle:
  - if e >= QH_LAT, shift sr_qh into the shadow register's LSB and increment the bit counter;
  - if the bit counter has reached W, go to DONE; otherwise go to PULSE.
- PULSE: one cycle with sr_clk_inh=0 and sr_shift_load=1; increment e, then go to WAIT.
- DONE: one cycle. data <= shadow; valid=1; changed=(shadow != previous data). Next state is LOAD if auto_scan or start is high, otherwise IDLE.
- Shift enables per scan: W-1+QH_LAT, excluding the load edge. The controller never issues a shift enable after the final sample.
- start while busy is ignored; there is no queueing. auto_scan dropping mid-scan lets the current scan finish, then the block returns to IDLE.
- data holds its value throughout a scan; only DONE writes it.
- Counter widths: bit counter clog2(W+1); edge counter clog2(W+QH_LAT+1); divider counter clog2(DIV).

## Timing
- Reset values: sr_clk_inh=1, sr_shift_load=1, data=0, valid=0, changed=0, busy=0, state IDLE, all counters 0.
- Reset asserted mid-scan: next cycle is IDLE with the reset values; any partial shadow contents are discarded.
- start seen in IDLE at cycle t: LOAD at t+1 and busy=1 at t+1.
- LOAD entry to DONE entry: DIV*(W+QH_LAT) cycles. Example: N_CHIPS=2, DIV=4, QH_LAT=1 gives 68.
- valid is asserted in the DONE cycle; data is registered and visible in that same cycle.
- Auto-scan period: DIV*(W+QH_LAT)+1 cycles.
- sr_clk_inh is low for exactly one cycle per PULSE and during LOAD, never for two consecutive cycles.
- sr_shift_load is low only in LOAD.
- sr_qh is sampled at least DIV-1 cycles after the most recent enabled edge.

## Structure
- Shared package hc165_pkg holds:
  - the state enum (IDLE, LOAD, WAIT, PULSE, DONE);
  - the constant CHIP_BITS=8;
  - a width function W(N_CHIPS).
- One sub-module: hc165_bit_timer, the DIV down-counter producing last_wait_cycle. Everything else stays in the top module.

## Test plan
- Chain of two chip models with q={8'hA5, 8'h3C}, DIV=4, QH_LAT=1; pulse start. Required: data=16'hA53C with valid at exactly 68 cycles after LOAD, changed=1, and 16 PULSE cycles.
- Repeat the scan with unchanged inputs. Required: valid=1, changed=0, data unchanged.
- auto_scan=1; change q to {8'hFF, 8'h00} during a scan. Required: the current scan reports a value that is stable for the scan, and the next scan reports 16'hFF00. valid strobes are spaced exactly 69 cycles apart.
- Assert start every cycle while busy. Required: exactly one scan, and no extra LOAD before DONE.
- Assert rst during the 5th WAIT. Required: next cycle sr_clk_inh=1, sr_shift_load=1, busy=0, data=0. A following start yields a correct 16'hA53C.
- DIV=2, QH_LAT=0, single chip, q=8'h81. Required: data=8'h81 after 16 cycles, 7 shift enables, and sr_clk_inh never low two cycles in a row.

Source files
------------

// File: rtl/hc165_pkg.sv
// Shared types and sizing helpers for the 74HC165 chain scan controller.
package hc165_pkg;

   localparam int CHIP_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT,
      PULSE,
      DONE
   } state_t;

   function automatic int W(input int n_chips);
      return CHIP_BITS * n_chips;
   endfunction

endpackage

// File: rtl/hc165_bit_timer.sv
// Bit-period down-counter: reloaded on every enabled chain edge, flags the last WAIT cycle.
module hc165_bit_timer #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic reload,
   output logic last_wait_cycle
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] RELOAD_VAL = CW'(DIV - 2);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (reload) begin
         cnt <= RELOAD_VAL;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign last_wait_cycle = (cnt == '0);

endmodule

// File: rtl/hc165_scan_ctrl.sv
// Scan sequencer for a daisy-chain of 74HC165 shift registers; deserialises QH into data.
//
//   state | meaning
//   IDLE  | chain held, waiting for start or auto_scan
//   LOAD  | parallel load edge (e = 0), counters and shadow cleared
//   WAIT  | DIV-1 inhibited cycles; QH sampled on the last one
//   PULSE | single shift-enabled cycle, e increments
//   DONE  | data/valid/changed published, rescan or return to IDLE
module hc165_scan_ctrl
   import hc165_pkg::*;
#(
   parameter int N_CHIPS = 2,
   parameter int DIV     = 4,
   parameter int QH_LAT  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  auto_scan,
   input  logic                  sr_qh,
   output logic                  sr_shift_load,
   output logic                  sr_clk_inh,
   output logic [W(N_CHIPS)-1:0] data,
   output logic                  valid,
   output logic                  changed,
   output logic                  busy
);

   localparam int DW  = W(N_CHIPS);
   localparam int BCW = $clog2(DW + 1);
   localparam int ECW = $clog2(DW + QH_LAT + 1);

   state_t         state, state_nxt;
   logic [BCW-1:0] bit_cnt;
   logic [ECW-1:0] e_cnt;
   logic [DW-1:0]  shadow;
   logic [DW-1:0]  shadow_nxt;
   logic           last_wait;
   logic           sample;
   logic           scan_end;

   hc165_bit_timer #(.DIV(DIV)) u_bit_timer (
      .clk             (clk),
      .rst             (rst),
      .reload          ((state == LOAD) || (state == PULSE)),
      .last_wait_cycle (last_wait)
   );

   // QH is only meaningful once the chain has seen QH_LAT enabled edges after the load.
   assign sample     = (state == WAIT) && last_wait && (int'(e_cnt) >= QH_LAT);
   assign scan_end   = sample && (bit_cnt == BCW'(DW - 1));
   assign shadow_nxt = {shadow[DW-2:0], sr_qh};
   assign busy       = (state != IDLE);

   always_comb begin
      state_nxt     = state;
      sr_shift_load = 1'b1;
      sr_clk_inh    = 1'b1;
      case (state)
         IDLE: begin
            if (start || auto_scan) state_nxt = LOAD;
         end
         LOAD: begin
            sr_shift_load = 1'b0;
            sr_clk_inh    = 1'b0;
            state_nxt     = WAIT;
         end
         WAIT: begin
            if (last_wait) state_nxt = scan_end ? DONE : PULSE;
         end
         PULSE: begin
            sr_clk_inh = 1'b0;
            state_nxt  = WAIT;
         end
         DONE: begin
            state_nxt = (auto_scan || start) ? LOAD : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // data/valid/changed are written on the edge entering DONE so they are visible in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
         e_cnt   <= '0;
         shadow  <= '0;
         data    <= '0;
         valid   <= 1'b0;
         changed <= 1'b0;
      end else begin
         state   <= state_nxt;
         valid   <= scan_end;
         changed <= scan_end && (shadow_nxt != data);
         if (state == LOAD) begin
            bit_cnt <= '0;
            e_cnt   <= '0;
            shadow  <= '0;
         end
         if (state == PULSE) e_cnt <= e_cnt + 1'b1;
         if (sample) begin
            shadow  <= shadow_nxt;
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (scan_end) data <= shadow_nxt;
      end
   end

endmodule

// File: tb/tb_hc165_scan_ctrl.sv
// Directed bench: two controller instances, each driving a behavioural 74HC165 chain model.
module tb_hc165_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        start_a = 1'b0, auto_a = 1'b0;
   logic        sl_a, inh_a, valid_a, changed_a, busy_a;
   logic [15:0] data_a;
   logic [15:0] q_a = 16'hA53C;
   logic [15:0] ch_a = '0;
   logic        qh_a = 1'b0;

   logic        start_b = 1'b0, auto_b = 1'b0;
   logic        sl_b, inh_b, valid_b, changed_b, busy_b;
   logic [7:0]  data_b;
   logic [7:0]  q_b = 8'h81;
   logic [7:0]  ch_b = '0;
   logic        qh_b;

   int checks = 0;
   int errors = 0;
   int dbl_low = 0;
   int bad_sl = 0;
   logic prev_inh_a = 1'b1, prev_inh_b = 1'b1;

   int  cyc, pul, lds;
   bit  got;

   always #5 clk = ~clk;

   hc165_scan_ctrl #(.N_CHIPS(2), .DIV(4), .QH_LAT(1)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .auto_scan(auto_a), .sr_qh(qh_a),
      .sr_shift_load(sl_a), .sr_clk_inh(inh_a), .data(data_a), .valid(valid_a),
      .changed(changed_a), .busy(busy_a)
   );

   hc165_scan_ctrl #(.N_CHIPS(1), .DIV(2), .QH_LAT(0)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .auto_scan(auto_b), .sr_qh(qh_b),
      .sr_shift_load(sl_b), .sr_clk_inh(inh_b), .data(data_b), .valid(valid_b),
      .changed(changed_b), .busy(busy_b)
   );

   // Chain A: {chip1=q_a[15:8] nearest the controller, chip0=q_a[7:0]}, registered QH.
   always @(posedge clk) begin
      if (!sl_a) begin
         ch_a <= q_a;
         qh_a <= ch_a[15];
      end else if (!inh_a) begin
         ch_a <= {ch_a[14:0], 1'b0};
         qh_a <= ch_a[15];
      end
   end

   // Chain B: single chip, combinational QH.
   always @(posedge clk) begin
      if (!sl_b) ch_b <= q_b;
      else if (!inh_b) ch_b <= {ch_b[6:0], 1'b0};
   end
   assign qh_b = ch_b[7];

   always @(negedge clk) begin
      prev_inh_a <= inh_a;
      prev_inh_b <= inh_b;
      if (!rst && ((!inh_a && !prev_inh_a) || (!inh_b && !prev_inh_b))) dbl_low <= dbl_low + 1;
      if (!rst && ((!sl_a && inh_a) || (!sl_b && inh_b))) bad_sl <= bad_sl + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Steps negedge by negedge until the selected instance strobes valid or the budget runs out.
   task automatic wait_valid(input bit sel, input bit hold_start, input int budget,
                             output int cycles, output int pulses, output int loads,
                             output bit seen);
      cycles = 0; pulses = 0; loads = 0; seen = 1'b0;
      while (!seen && cycles < budget) begin
         @(negedge clk);
         cycles++;
         if (!hold_start) begin
            start_a = 1'b0;
            start_b = 1'b0;
         end
         if (!sel) begin
            if (!inh_a && sl_a) pulses++;
            if (!sl_a) loads++;
            seen = valid_a;
         end else begin
            if (!inh_b && sl_b) pulses++;
            if (!sl_b) loads++;
            seen = valid_b;
         end
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_inh", inh_a, 1);
      check("rst_sl", sl_a, 1);
      check("rst_data", data_a, 0);
      check("rst_valid", valid_a, 0);
      check("rst_changed", changed_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_busy_b", busy_b, 0);

      // first scan
      start_a = 1'b1;
      wait_valid(0, 0, 200, cyc, pul, lds, got);
      check("s1_got", got, 1);
      check("s1_latency", cyc - 1, 68);
      check("s1_pulses", pul, 16);
      check("s1_loads", lds, 1);
      check("s1_data", data_a, 16'hA53C);
      check("s1_changed", changed_a, 1);
      @(negedge clk);
      check("s1_valid_once", valid_a, 0);
      check("s1_idle", busy_a, 0);

      // repeat with unchanged inputs
      start_a = 1'b1;
      wait_valid(0, 0, 200, cyc, pul, lds, got);
      check("s2_got", got, 1);
      check("s2_latency", cyc - 1, 68);
      check("s2_data", data_a, 16'hA53C);
      check("s2_changed", changed_a, 0);
      @(negedge clk);

      // start held high throughout the scan
      start_a = 1'b1;
      wait_valid(0, 1, 200, cyc, pul, lds, got);
      start_a = 1'b0;
      check("s3_got", got, 1);
      check("s3_loads", lds, 1);
      check("s3_data", data_a, 16'hA53C);
      @(negedge clk);
      check("s3_idle", busy_a, 0);

      // auto scan with inputs changing mid-scan
      auto_a = 1'b1;
      repeat (10) @(negedge clk);
      q_a = 16'hFF00;
      wait_valid(0, 0, 200, cyc, pul, lds, got);
      check("a1_got", got, 1);
      check("a1_data", data_a, 16'hA53C);
      check("a1_changed", changed_a, 0);
      wait_valid(0, 0, 200, cyc, pul, lds, got);
      check("a2_got", got, 1);
      check("a2_period", cyc, 69);
      check("a2_data", data_a, 16'hFF00);
      check("a2_changed", changed_a, 1);
      repeat (5) @(negedge clk);
      auto_a = 1'b0;
      wait_valid(0, 0, 200, cyc, pul, lds, got);
      check("a3_got", got, 1);
      check("a3_period", cyc + 5, 69);
      check("a3_changed", changed_a, 0);
      repeat (3) @(negedge clk);
      check("a3_idle", busy_a, 0);

      // reset during the fifth WAIT
      q_a = 16'hA53C;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      check("r_load_sl", sl_a, 0);
      check("r_load_busy", busy_a, 1);
      repeat (18) @(negedge clk);
      check("r_wait_inh", inh_a, 1);
      check("r_wait_busy", busy_a, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("r_inh", inh_a, 1);
      check("r_sl", sl_a, 1);
      check("r_busy", busy_a, 0);
      check("r_data", data_a, 0);
      start_a = 1'b1;
      wait_valid(0, 0, 200, cyc, pul, lds, got);
      check("r_got", got, 1);
      check("r_latency", cyc - 1, 68);
      check("r_result", data_a, 16'hA53C);
      check("r_changed", changed_a, 1);
      @(negedge clk);

      // single chip, DIV=2, combinational QH
      start_b = 1'b1;
      wait_valid(1, 0, 100, cyc, pul, lds, got);
      check("b_got", got, 1);
      check("b_latency", cyc - 1, 16);
      check("b_pulses", pul, 7);
      check("b_data", data_b, 8'h81);
      check("b_changed", changed_b, 1);
      @(negedge clk);

      check("inh_double_low", dbl_low, 0);
      check("sl_without_clk", bad_sl, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
